// File: rtl/pipe_ex_driver_pkg.sv
// Shared constants and helpers for the pipelined-datapath front end.
package pipe_ex_driver_pkg;

    localparam int unsigned N_DEF     = 10;
    localparam int unsigned LAT_DEF   = 3;
    localparam int unsigned DEPTH_DEF = 8;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_ex_driver_sync_fifo.sv
// Synchronous FIFO with a registered head word: dout is valid the edge after
// the first write into an empty FIFO, and pop+push on a full FIFO are both honoured.
module sync_fifo
    import pipe_ex_driver_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [ptr_w(DEPTH):0] count
);
    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_nxt;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign rd_nxt  = rd_ptr_q + PW'(1);

    assign dout  = dout_q;
    assign count = count_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_en)  rd_ptr_d = rd_nxt;
        // Head register: bypass din when the FIFO is (or is about to be) empty.
        if (push_en && (empty || (pop_en && count_q == CW'(1)))) begin
            dout_d = din;
        end else if (pop_en && count_q > CW'(1)) begin
            dout_d = mem_q[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pipe_ex_driver.sv
// Host front end for a fixed-latency, non-stallable 4-operand datapath:
// operand FIFO, credit-gated issue, latency tracking and result FIFO.
module pipe_ex_driver
    import pipe_ex_driver_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned LAT   = LAT_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic [N-1:0] in_d,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic [N-1:0] d,
    input  logic [N-1:0] f,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_f,
    output logic         busy
);
    localparam int unsigned CW  = ptr_w(DEPTH) + 1;
    localparam int unsigned OPW = 4 * N;

    logic [OPW-1:0] op_dout;
    logic           op_push;
    logic           op_full;
    logic           op_empty;
    logic [CW-1:0]  op_count_unused;
    logic [CW-1:0]  res_count_unused;
    logic           res_full_unused;
    logic           res_empty;
    logic           res_pop;
    logic           issue_c;
    logic           capture;
    logic [LAT-1:0] issue_q, issue_d;
    logic [CW-1:0]  credits_q, credits_d;
    logic [OPW-1:0] ops_q, ops_d;

    assign in_ready  = !op_full;
    assign op_push   = in_valid && !op_full;
    assign out_valid = !res_empty;
    assign res_pop   = !res_empty && out_ready;
    assign issue_c   = !op_empty && (credits_q != '0);
    assign capture   = issue_q[LAT-1];
    assign busy      = !op_empty || (|issue_q) || !res_empty;

    assign a = ops_q[4*N-1:3*N];
    assign b = ops_q[3*N-1:2*N];
    assign c = ops_q[2*N-1:N];
    assign d = ops_q[N-1:0];

    sync_fifo #(.W(OPW), .DEPTH(DEPTH)) u_op_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_push),
        .din   ({in_a, in_b, in_c, in_d}),
        .pop   (issue_c),
        .dout  (op_dout),
        .full  (op_full),
        .empty (op_empty),
        .count (op_count_unused)
    );

    // Credits guarantee room, so capture never needs back-pressure.
    sync_fifo #(.W(N), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (f),
        .pop   (res_pop),
        .dout  (out_f),
        .full  (res_full_unused),
        .empty (res_empty),
        .count (res_count_unused)
    );

    // Issue tracking, credit accounting and operand register next-state.
    always_comb begin
        issue_d   = LAT'({issue_q, issue_c});
        credits_d = credits_q;
        ops_d     = ops_q;
        case ({issue_c, res_pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
        if (issue_c) ops_d = op_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q   <= '0;
            credits_q <= CW'(DEPTH);
            ops_q     <= '0;
        end else begin
            issue_q   <= issue_d;
            credits_q <= credits_d;
            ops_q     <= ops_d;
        end
    end

endmodule

// File: tb/tb_pipe_ex_driver.sv
// Scoreboard bench for pipe_ex_driver with a behavioural datapath model.
module tb_pipe_ex_driver;
    localparam int unsigned N     = 10;
    localparam int unsigned LAT   = 3;
    localparam int unsigned DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a, in_b, in_c, in_d;
    logic [N-1:0] a, b, c, d;
    logic [N-1:0] f;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_f;
    logic         busy;

    always #5 clk = ~clk;

    pipe_ex_driver #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .busy      (busy)
    );

    // Datapath: the DUT's operand registers are stage one, LAT-1 more follow.
    logic [N-1:0] dp_q [LAT-1];
    always_ff @(posedge clk) begin
        dp_q[0] <= a + b + c - d;
        for (int i = 1; i < LAT - 1; i++) dp_q[i] <= dp_q[i-1];
    end
    assign f = dp_q[LAT-2];

    logic [N-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int issue_cnt = 0;
    logic [4*N-1:0] prev_ops = '0;

    function automatic logic [N-1:0] model_f(input int unsigned x, y, z, w);
        return N'(x + y + z - w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, req);
        end
    endtask

    // Result monitor: every accepted output is checked against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %0d, wanted none", out_f);
            end else begin
                check("result", 32'(out_f), 32'(exp_q.pop_front()));
            end
        end
    end

    // Every issue loads a fresh operand set, so changes on a..d count issues.
    always @(negedge clk) begin
        if ({a, b, c, d} != prev_ops) issue_cnt++;
        prev_ops = {a, b, c, d};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_q(input logic [N-1:0] x, y, z, w);
        bit done;
        done = 1'b0;
        in_a = x; in_b = y; in_c = z; in_d = w;
        in_valid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model_f(32'(x), 32'(y), 32'(z), 32'(w)));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got in_ready=0, wanted 1 within 500 cycles");
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        check({name, "_drained"}, 32'(ok), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_busy_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int base;
        bit seen;
        bit pushes_done;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        repeat (3) tick();
        check("rst_a", 32'(a), 0);
        check("rst_b", 32'(b), 0);
        check("rst_c", 32'(c), 0);
        check("rst_d", 32'(d), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_f", 32'(out_f), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Single transaction with exact latency.
        push_q(10, 12, 6, 3);
        in_valid = 1'b0;
        tick();
        check("t1_a", 32'(a), 10);
        check("t1_b", 32'(b), 12);
        check("t1_c", 32'(c), 6);
        check("t1_d", 32'(d), 3);
        tick();
        tick();
        check("t1_out_valid_early", 32'(out_valid), 0);
        tick();
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_f", 32'(out_f), 25);
        check("t1_busy", 32'(busy), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_out_valid_after_pop", 32'(out_valid), 0);
        check("t1_busy_after_pop", 32'(busy), 0);

        // Back-to-back streaming, results on consecutive cycles.
        out_ready = 1'b1;
        push_q(10, 10, 5, 3);
        push_q(20, 11, 1, 4);
        push_q(15, 10, 8, 2);
        push_q(8, 15, 5, 0);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t2_first_result", 32'(seen), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_no_gap", 32'(out_valid), 1);
        end
        @(negedge clk);
        check("t2_stream_end", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        drain("t2");

        // Credit stall: 8 issues, op FIFO fills, one issue per freed credit.
        base = issue_cnt;
        for (int i = 0; i < 16; i++) push_q(N'(500 + i), N'(600 + i), N'(700 + i), N'(i));
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        repeat (4) tick();
        check("t3_issues_stalled", 32'(issue_cnt - base), 8);
        check("t3_in_ready_still_low", 32'(in_ready), 0);
        for (int p = 1; p <= 3; p++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            repeat (6) tick();
            check("t3_issue_per_pulse", 32'(issue_cnt - base), 32'(8 + p));
            check("t3_in_ready_freed", 32'(in_ready), 1);
        end
        drain("t3");

        // Random traffic over several pointer wraps.
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                    push_q(N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)),
                           N'($urandom_range(0, 1023)), N'($urandom_range(0, 1023)));
                end
                in_valid = 1'b0;
                pushes_done = 1'b1;
            end
            begin
                for (int t = 0; t < 3000 && !(pushes_done && exp_q.size() == 0); t++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b0;
            end
        join
        check("t4_all_results_seen", 32'(exp_q.size()), 0);
        drain("t4");

        // Same-edge issue/pop and capture/pop after a full stall.
        base = issue_cnt;
        for (int i = 0; i < 12; i++) push_q(N'(100 + i), N'(200 + i), N'(300 + i), N'(i));
        in_valid = 1'b0;
        repeat (8) tick();
        check("t5_issues_stalled", 32'(issue_cnt - base), 8);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (8) tick();
        check("t5_issues_after_release", 32'(issue_cnt - base), 12);
        check("t5_out_valid", 32'(out_valid), 1);
        drain("t5");
        base = issue_cnt;
        for (int i = 0; i < 9; i++) push_q(N'(400 + i), N'(800 + i), N'(50 + i), N'(i));
        in_valid = 1'b0;
        repeat (10) tick();
        check("t5_credits_restored", 32'(issue_cnt - base), 8);
        drain("t5b");

        // Reset with 2 results buffered and 3 issues in flight.
        for (int i = 0; i < 5; i++) push_q(N'(30 + i), N'(40 + i), N'(60 + i), N'(i));
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_ops", 32'({a, b, c, d} != '0), 0);
        check("t6_busy", 32'(busy), 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("t6_no_late_capture", 32'(seen), 0);
        @(posedge clk);
        #1;
        push_q(1, 2, 3, 4);
        in_valid = 1'b0;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, wanted finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
